// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: opcode encodings and flag-vector bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam int FLG_COUT = 0;
  localparam int FLG_ZERO = 1;
  localparam int FLG_NEG  = 2;
  localparam int FLG_OVF  = 3;
  localparam int FLG_W    = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus carry/zero/negative/overflow flags.
// Optional macro ALU_SAT_EN clamps ADD/SUB results to the signed limit on overflow.
import alu_pkg::*;

module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       sel_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] result_o,
  output logic [FLG_W-1:0] flags_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] res_s;
  logic             cout_s;
  logic             ovf_s;

  always_comb begin
    sum_s  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    // Bit WIDTH of the extended difference is the borrow, including the B=all-ones, Cin=1 case.
    diff_s = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
    raw_s  = '0;
    cout_s = 1'b0;
    ovf_s  = 1'b0;
    case (sel_i)
      OP_ADD: begin
        raw_s  = sum_s[MSB:0];
        cout_s = sum_s[WIDTH];
        ovf_s  = (a_i[MSB] == b_i[MSB]) && (sum_s[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        raw_s  = diff_s[MSB:0];
        cout_s = diff_s[WIDTH];
        ovf_s  = (a_i[MSB] != b_i[MSB]) && (diff_s[MSB] != a_i[MSB]);
      end
      OP_AND: raw_s = a_i & b_i;
      OP_OR:  raw_s = a_i | b_i;
      OP_XOR: raw_s = a_i ^ b_i;
      OP_NOT: raw_s = ~a_i;
      OP_SHL: begin
        raw_s  = {a_i[MSB-1:0], 1'b0};
        cout_s = a_i[MSB];
      end
      OP_SHR: begin
        raw_s  = {1'b0, a_i[MSB:1]};
        cout_s = a_i[0];
      end
      default: raw_s = '0;
    endcase
  end

`ifdef ALU_SAT_EN
  // Overflow direction follows A's sign: positive A can only overflow upward.
  assign res_s = !ovf_s       ? raw_s :
                 a_i[MSB]     ? {1'b1, {(WIDTH-1){1'b0}}} :
                                {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_s = raw_s;
`endif

  assign result_o          = res_s;
  assign flags_o[FLG_COUT] = cout_s;
  assign flags_o[FLG_ZERO] = (res_s == '0);
  assign flags_o[FLG_NEG]  = res_s[MSB];
  assign flags_o[FLG_OVF]  = ovf_s;

endmodule

// File: rtl/alu_pipe_top.sv
// Two-stage valid/ready pipelined ALU with registered flags and a saturating overflow counter.
// Build option: ALU_SAT_EN (saturating ADD/SUB, handled inside alu_core).
import alu_pkg::*;

module alu_pipe_top #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic [CNT_W-1:0] ovf_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic             cin_q, cin_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [FLG_W-1:0] flg_q, flg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_adv_s;
  logic             in_ready_s;
  logic [WIDTH-1:0] core_res_s;
  logic [FLG_W-1:0] core_flg_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .sel_i    (sel_q),
    .cin_i    (cin_q),
    .result_o (core_res_s),
    .flags_o  (core_flg_s)
  );

  always_comb begin
    s2_adv_s    = !out_valid_q || out_ready;
    in_ready_s  = !s1_valid_q || s2_adv_s;
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    cin_d       = cin_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    flg_d       = flg_q;
    cnt_d       = cnt_q;

    if (in_ready_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d   = A;
        b_d   = B;
        sel_d = ALU_Sel;
        cin_d = Cin;
      end
    end

    // Stage-2 data only changes when a real beat moves in, so idle gaps keep the last result.
    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d = core_res_s;
        flg_d = core_flg_s;
      end
    end

    if (out_valid_q && out_ready && flg_q[FLG_OVF] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 3'd0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flg_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flg_q       <= flg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign Result    = res_q;
  assign Cout      = flg_q[FLG_COUT];
  assign Zero      = flg_q[FLG_ZERO];
  assign Negative  = flg_q[FLG_NEG];
  assign Overflow  = flg_q[FLG_OVF];
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_pipe_top.sv
// Self-checking bench for alu_pipe_top: directed cases, backpressure, reset, counter saturation, random traffic.
module tb_alu_pipe_top;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, Cin;
  logic [7:0] A, B;
  logic [2:0] ALU_Sel;
  logic       in_ready, out_valid, Cout, Zero, Negative, Overflow;
  logic [7:0] Result;
  logic [15:0] ovf_count;
  logic       in_ready2, out_valid2, Cout2, Zero2, Negative2, Overflow2;
  logic [7:0] Result2;
  logic [1:0] ovf_count2;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  int delivered = 0;
  exp_t exp_q[$];
  logic [7:0] out_log[$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_res;
  logic [3:0] prev_flg;

  always #5 clk = ~clk;

  alu_pipe_top #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .Cout(Cout), .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
    .ovf_count(ovf_count)
  );

  alu_pipe_top #(.WIDTH(W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .Cin(Cin),
    .out_valid(out_valid2), .out_ready(out_ready), .Result(Result2),
    .Cout(Cout2), .Zero(Zero2), .Negative(Negative2), .Overflow(Overflow2),
    .ovf_count(ovf_count2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model in signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] sel, input logic cin);
    exp_t e;
    int ua, ub, sa, sb, t, s;
    ua = int'(a);
    ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    s = 0;
    e = '0;
    case (sel)
      3'd0: begin
        t = ua + ub + int'(cin);
        e.r = t[7:0];
        e.c = (t >= 256);
        s = sa + sb + int'(cin);
        e.v = (s > 127) || (s < -128);
      end
      3'd1: begin
        t = ua - ub - int'(cin) + 256;
        e.r = t[7:0];
        e.c = (ua < ub + int'(cin));
        s = sa - sb - int'(cin);
        e.v = (s > 127) || (s < -128);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = ~a;
      3'd6: begin t = (ua * 2) % 256; e.r = t[7:0]; e.c = a[7]; end
      default: begin t = ua / 2; e.r = t[7:0]; e.c = a[0]; end
    endcase
`ifdef ALU_SAT_EN
    if (e.v) e.r = (s > 127) ? 8'h7F : 8'h80;
`endif
    e.z = (e.r == 8'h00);
    e.n = e.r[7];
    return e;
  endfunction

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // Scoreboard, stall-stability and input capture, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_result", 32'(Result), 32'(prev_res));
        check_eq("stall_flags", {28'd0, Cout, Zero, Negative, Overflow}, {28'd0, prev_flg});
      end
      prev_stall = out_valid && !out_ready;
      prev_res = Result;
      prev_flg = {Cout, Zero, Negative, Overflow};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_result", 32'(Result), 32'(e.r));
          check_eq("sb_cout", 32'(Cout), 32'(e.c));
          check_eq("sb_zero", 32'(Zero), 32'(e.z));
          check_eq("sb_neg", 32'(Negative), 32'(e.n));
          check_eq("sb_ovf", 32'(Overflow), 32'(e.v));
          check_eq("sb_cnt16", 32'(ovf_count), 32'(model_cnt));
          check_eq("sb_cnt2", 32'(ovf_count2), 32'(sat3(model_cnt)));
          if (e.v) model_cnt++;
        end
        out_log.push_back(Result);
        delivered++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, ALU_Sel, Cin));
    end
  end

  // Single beat into an empty pipe with out_ready=1: checks latency, content and counters.
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                          input logic cin, input logic [7:0] er, input logic ec,
                          input logic ev, input int ecnt);
    @(posedge clk); #1;
    in_valid = 1'b1; A = a; B = b; ALU_Sel = sel; Cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("d_result", 32'(Result), 32'(er));
    check_eq("d_cout", 32'(Cout), 32'(ec));
    check_eq("d_ovf", 32'(Overflow), 32'(ev));
    check_eq("d_zero", 32'(Zero), 32'(er == 8'h00));
    check_eq("d_neg", 32'(Negative), 32'(er[7]));
    @(negedge clk);
    check_eq("d_cnt16", 32'(ovf_count), 32'(ecnt));
    check_eq("d_cnt2", 32'(ovf_count2), 32'(sat3(ecnt)));
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corner[4];
    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sat_r;
    int idx, base, n;
    logic saw_block, acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = 8'h00; B = 8'h00; ALU_Sel = 3'd0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_result", 32'(Result), 32'd0);
    check_eq("rst_flags", {28'd0, Cout, Zero, Negative, Overflow}, 32'd0);
    check_eq("rst_cnt", 32'(ovf_count), 32'd0);

`ifdef ALU_SAT_EN
    sat_r = 8'h7F;
`else
    sat_r = 8'h80;
`endif
    send_one(8'h7F, 8'h01, 3'd0, 1'b0, sat_r, 1'b0, 1'b1, 1);
    send_one(8'h05, 8'h05, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    send_one(8'h00, 8'h01, 3'd1, 1'b0, 8'hFF, 1'b1, 1'b0, 1);
    send_one(8'h81, 8'h00, 3'd6, 1'b0, 8'h02, 1'b1, 1'b0, 1);
    send_one(8'h81, 8'h00, 3'd7, 1'b0, 8'h40, 1'b1, 1'b0, 1);
    send_one(8'h0F, 8'h00, 3'd5, 1'b0, 8'hF0, 1'b0, 1'b0, 1);
    send_one(8'h00, 8'hFF, 3'd1, 1'b1, 8'h00, 1'b1, 1'b0, 1);

    // Backpressure: four ADDs streamed while the consumer stalls for cycles 2..5.
    idx = 0; saw_block = 1'b0; base = delivered;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 2 && cyc <= 5);
      in_valid = (idx < 4);
      A = 8'(idx + 1); B = 8'(idx + 1); ALU_Sel = 3'd0; Cin = 1'b0;
      @(negedge clk);
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    check_eq("bp_in_ready_low", 32'(saw_block), 32'd1);
    check_eq("bp_accepted", 32'(idx), 32'd4);
    check_eq("bp_delivered", 32'(delivered - base), 32'd4);
    n = out_log.size();
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_order", 32'(out_log[n - 4 + k]), 32'(2 * (k + 1)));
    end

    // Reset with two beats buffered behind a stalled consumer.
    out_ready = 1'b0; idx = 0;
    for (int cyc = 0; cyc < 10 && idx < 2; cyc++) begin
      in_valid = 1'b1; A = 8'h7F; B = 8'h01; ALU_Sel = 3'd0; Cin = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check_eq("rstm_accepted", 32'(idx), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rstm_out_valid", 32'(out_valid), 32'd0);
    check_eq("rstm_result", 32'(Result), 32'd0);
    check_eq("rstm_cnt", 32'(ovf_count), 32'd0);
    check_eq("rstm_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; base = delivered;
    repeat (5) @(negedge clk);
    check_eq("rstm_no_ghost", 32'(delivered - base), 32'd0);

    // Counter saturation on the CNT_W=2 instance: 1, 2, 3, 3, 3.
    for (int k = 1; k <= 5; k++) begin
      send_one(8'h7F, 8'h01, 3'd0, 1'b0, sat_r, 1'b0, 1'b1, k);
    end

    // Random traffic with random backpressure.
    in_valid = 1'b0; acc = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        A = pick_operand(); B = pick_operand();
        ALU_Sel = 3'($urandom_range(0, 7));
        Cin = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe_top.md
Name: alu_pipe_top

Overview:
- Parametrised, two-stage pipelined ALU with valid/ready handshakes on input and output.
- Registered status flags and an overflow event counter.
- Next-generation registered ALU top: generalised operand width, backpressure support, flags exposed.
- Sits between operand sources and result consumers in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (minimum 2).
- CNT_W, 16, width of the saturating overflow event counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALU_Sel  input  3  operation select.
- Cin  input  1  carry/borrow in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- Result  output  WIDTH  result.
- Cout  output  1  carry out / borrow / shifted-out bit.
- Zero  output  1  Result == 0.
- Negative  output  1  Result[WIDTH-1].
- Overflow  output  1  signed overflow (ADD/SUB only).
- ovf_count  output  CNT_W  number of delivered beats with Overflow=1, saturating.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high, and applies on a rising edge of clk.
- Reset values: all valids 0; all data and flag registers 0; ovf_count 0. in_ready is 1 in the first cycle after reset. Reset mid-operation discards in-flight beats with no output.
- Operations by ALU_Sel:
  - 000 ADD: A+B+Cin.
  - 001 SUB: A-B-Cin.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 SHL A by 1.
  - 111 SHR A by 1, logical.
- Arithmetic is WIDTH bits; results wrap modulo 2^WIDTH.
- Cout:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow, i.e. 1 iff unsigned A < B+Cin.
  - SHL: A[WIDTH-1]. SHR: A[0].
  - Logic operations: 0.
- Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
  - All other operations: 0.
- Pipeline:
  - Stage 1 registers A, B, ALU_Sel and Cin on in_valid && in_ready.
  - Stage 2 registers Result and the flags computed from the stage-1 contents.
- Latency: a beat accepted at edge N is presented at edge N+2 when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - stage2 advances when !out_valid || out_ready.
  - stage1 advances when !s1_valid || stage2 advances.
  - in_ready = !s1_valid || stage2 advances (combinational from out_ready; no path from in_valid).
- Transfers: an input transfer occurs on in_valid && in_ready; an output transfer occurs on out_valid && out_ready.
- Stalls: while out_valid && !out_ready, Result, all flags and out_valid hold stable. Up to 2 beats are buffered; no beat is lost or duplicated; order is preserved.
- Simultaneous events: input and output transfers in the same cycle are both honoured.
- ovf_count: increments on each output transfer with Overflow=1. It holds at 2^CNT_W-1 once saturated.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD and SUB results clamp to the signed limit on signed overflow. Positive overflow gives 0 followed by all 1s; negative overflow gives 1 followed by all 0s. Overflow and Cout still report the unclamped condition. Zero and Negative follow the clamped Result.
- Undefined: results wrap; there is no clamp logic.

Decomposition:
- Package alu_pkg:
  - Opcode localparams: OP_ADD..OP_SHR = 3'd0..3'd7.
  - Flag-vector index constants: FLG_COUT, FLG_ZERO, FLG_NEG, FLG_OVF.
- Sub-module alu_core: purely combinational, parametrised by WIDTH. Computes Result and the 4 flags (including the ALU_SAT_EN clamp).
- alu_pipe_top holds the pipeline registers, the handshake logic and the counter.

Test Plan:
- WIDTH=8, out_ready=1, ADD A=0x7F B=0x01 Cin=0 -> two cycles later Result=0x80, Overflow=1, Negative=1, Cout=0, Zero=0, ovf_count=1. With ALU_SAT_EN: Result=0x7F, Negative=0.
- SUB A=0x05 B=0x05 Cin=0 -> Result=0x00, Zero=1, Cout=0. Then SUB A=0x00 B=0x01 -> Result=0xFF, Cout=1, Negative=1, Overflow=0.
- SHL A=0x81 -> Result=0x02, Cout=1. SHR A=0x81 -> Result=0x40, Cout=1. NOT A=0x0F -> Result=0xF0.
- Backpressure: stream 4 ADDs (1+1, 2+2, 3+3, 4+4) with out_ready=0 for cycles 2..5:
  - in_ready deasserts after 2 beats are held.
  - Output sequence is 0x02, 0x04, 0x06, 0x08, with no gaps lost and no duplicates.
  - Result is stable while stalled.
- Reset mid-flight: 2 beats accepted, rst high 1 cycle -> out_valid=0, Result=0, ovf_count=0 next cycle; the dropped beats never appear.
- CNT_W=2: 5 overflowing ADDs delivered -> ovf_count reads 1, 2, 3, 3, 3.
